// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DIGITS    = 3;
    localparam int ADJ_THRESHOLD = 5;
    localparam int ADJ_OFFSET    = 3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before it is doubled.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // The sum wraps in 4 bits; a digit <= 9 plus 3 never exceeds 12, so no carry is lost.
    assign adjusted = (digit >= 4'(ADJ_THRESHOLD)) ? digit + 4'(ADJ_OFFSET) : digit;

endmodule

// File: rtl/bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift-add-3 step per clock.
// Optional sign path is enabled by defining BCD_SIGN_EN.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    input  logic                  negative,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t                state;
    logic [WIDTH-1:0]      shift_reg;
    logic [4*DIGITS-1:0]   scratch;
    logic [4*DIGITS-1:0]   adj;
    logic [4*DIGITS-1:0]   scratch_next;
    logic [CW-1:0]         count;

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_digit_adj u_adj (
            .digit    (scratch[4*d +: 4]),
            .adjusted (adj[4*d +: 4])
        );
    end

    // Upper half of the combined {scratch, shift_reg} left shift.
    assign scratch_next = {adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};

`ifdef BCD_SIGN_EN
    logic sign_hold;
`else
    logic unused_negative;
    assign unused_negative = negative;
    assign sign            = 1'b0;
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            scratch   <= '0;
            count     <= '0;
            bcd       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef BCD_SIGN_EN
            sign_hold <= 1'b0;
            sign      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= binary;
                        scratch   <= '0;
                        count     <= '0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
`ifdef BCD_SIGN_EN
                        sign_hold <= negative;
`endif
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    scratch   <= scratch_next;
                    count     <= count + 1'b1;
                    // Final shift: publish the result; bcd never shows partial values.
                    if (count == CW'(WIDTH - 1)) begin
                        bcd   <= scratch_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef BCD_SIGN_EN
                        sign  <= sign_hold;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: directed conversions, latency, hold, abort and back-to-back.
module tb_bcd_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [WIDTH-1:0]    binary;
    logic                negative;
    logic [4*DIGITS-1:0] bcd;
    logic                sign;
    logic                busy;
    logic                done;

    bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .binary   (binary),
        .negative (negative),
        .bcd      (bcd),
        .sign     (sign),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        logic                sign;
        int                  acc;
    } exp_t;

    exp_t                q[$];
    int                  cycle_cnt = 0;
    int                  n_checks  = 0;
    int                  n_fail    = 0;
    int                  last_acc  = 0;
    logic [4*DIGITS-1:0] last_bcd  = '0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle_cnt, act, exp);
        end
    endtask

    function automatic logic exp_sign(input logic n);
`ifdef BCD_SIGN_EN
        return n;
`else
        return 1'b0;
`endif
    endfunction

    // Monitor: compares against the front of the scoreboard once it has been accepted.
    always @(negedge clk) begin : monitor
        int off;
        if (!reset) begin
            if (q.size() > 0 && cycle_cnt >= q[0].acc) begin
                off = cycle_cnt - q[0].acc;
                if (off < WIDTH) begin
                    check("busy_during", 32'(busy), 32'd1);
                    check("done_early", 32'(done), 32'd0);
                    check("bcd_hold_busy", 32'(bcd), 32'(last_bcd));
                end else begin
                    check("done_latency", 32'(done), 32'd1);
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("bcd_result", 32'(bcd), 32'(q[0].bcd));
                    check("sign_result", 32'(sign), 32'(q[0].sign));
                    last_bcd = q[0].bcd;
                    void'(q.pop_front());
                end
            end else begin
                check("done_idle", 32'(done), 32'd0);
                check("bcd_hold_idle", 32'(bcd), 32'(last_bcd));
            end
        end
    end

    task automatic do_conv(input logic [WIDTH-1:0] b, input logic n,
                           input logic [4*DIGITS-1:0] e, input bit hold = 1'b0);
        int t = 0;
        @(negedge clk);
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
        binary   = b;
        negative = n;
        start    = 1'b1;
        last_acc = cycle_cnt + 1;
        q.push_back('{bcd: e, sign: exp_sign(n), acc: last_acc});
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin : stimulus
        int acc200;
        int t;
        reset    = 1'b1;
        start    = 1'b0;
        binary   = '0;
        negative = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_sign", 32'(sign), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        do_conv(8'd255, 1'b0, 12'h255);
        do_conv(8'd1,   1'b1, 12'h001);
        do_conv(8'd0,   1'b1, 12'h000);
        do_conv(8'd0,   1'b0, 12'h000);
        do_conv(8'd99,  1'b0, 12'h099);
        do_conv(8'd77,  1'b1, 12'h077);

        // start held high; binary changes mid-flight and is only taken at the next accept.
        do_conv(8'd42, 1'b0, 12'h042, 1'b1);
        acc200 = last_acc + WIDTH + 1;
        repeat (3) @(negedge clk);
        binary = 8'd200;
        q.push_back('{bcd: 12'h200, sign: 1'b0, acc: acc200});
        while (cycle_cnt < acc200) @(negedge clk);
        start = 1'b0;

        // Abort 137 after four iterations.
        do_conv(8'd137, 1'b0, 12'h137);
        while (cycle_cnt < last_acc + 4) @(negedge clk);
        #2 reset = 1'b1;
        q.delete();
        #1;
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_sign", 32'(sign), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort_done_later", 32'(done), 32'd0);
        last_bcd = '0;
        #2 reset = 1'b0;
        do_conv(8'd137, 1'b0, 12'h137);

        // Back-to-back: second start lands on the edge after done.
        do_conv(8'd99,  1'b0, 12'h099);
        do_conv(8'd100, 1'b1, 12'h100);

        t = 0;
        while (q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain", 32'(q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
